// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared register-file writeback constants and request type
package rf_ctrl_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting the search at ptr, wrapping modulo N
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[IW'((int'(ptr) + k) % N)]) gnt_idx = IW'((int'(ptr) + k) % N);
    gnt = '0;
    gnt[gnt_idx] = |req;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin writeback arbiter with registered RF write port and pending-write scoreboard
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DEPTH = 32,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*RF_ADDR_W-1:0] req_addr,
  input  logic [NREQ*XLEN-1:0]      req_data,
  input  logic                      iss_valid,
  input  logic [RF_ADDR_W-1:0]      iss_rd,
  input  logic                      flush,
  input  logic [RF_ADDR_W-1:0]      chk_ra1,
  input  logic [RF_ADDR_W-1:0]      chk_ra2,
  output logic                      hazard1,
  output logic                      hazard2,
  output logic                      rf_we,
  output logic [RF_ADDR_W-1:0]      rf_wa,
  output logic [XLEN-1:0]           rf_wd,
  output logic [DEPTH-1:0]          busy
);
  logic [IW-1:0] r_ptr, w_gnt_idx;
  logic [NREQ-1:0] w_gnt;
  logic r_we;
  logic [RF_ADDR_W-1:0] r_wa;
  logic [XLEN-1:0] r_wd;
  logic [DEPTH-1:0] r_busy, w_busy_nxt;
  wb_req_t w_src [NREQ];
  wb_req_t w_sel;
  logic w_fire;
  rr_arbiter #(.N(NREQ)) u_rr (.req(req_valid), .ptr(r_ptr), .gnt(w_gnt), .gnt_idx(w_gnt_idx));
  always_comb for (int i = 0; i < NREQ; i++)
    w_src[i] = '{addr: req_addr[RF_ADDR_W*i +: RF_ADDR_W], data: req_data[XLEN*i +: XLEN]};
  assign w_sel = w_src[w_gnt_idx];
  assign req_ready = rst ? '0 : w_gnt;
  assign w_fire = |req_ready;
  always_comb begin
    w_busy_nxt = flush ? '0 : r_busy;
    if (r_we) w_busy_nxt[r_wa] = 1'b0;
    if (iss_valid) w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we <= w_fire && w_sel.addr != '0;
      if (w_fire) begin
        r_ptr <= w_gnt_idx == IW'(NREQ - 1) ? '0 : w_gnt_idx + 1'b1;
        r_wa <= w_sel.addr;
        r_wd <= w_sel.data;
      end
    end
  end
  assign rf_we = r_we;
  assign rf_wa = r_wa;
  assign rf_wd = r_wd;
  assign busy = r_busy;
  assign hazard1 = r_busy[chk_ra1];
  assign hazard2 = r_busy[chk_ra2];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenario table, reset sequence and randomized run against a reference model
module tb_rf_wb_arbiter;
  localparam int N = 3;
  localparam logic [31:0] DA = 32'hAAAA_0001, DB = 32'hBBBB_0002, DC = 32'hCCCC_0003;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*5-1:0] req_addr;
  logic [N*32-1:0] req_data;
  logic iss_valid, flush, hazard1, hazard2, rf_we;
  logic [4:0] iss_rd, chk_ra1, chk_ra2, rf_wa;
  logic [31:0] rf_wd, busy;
  int n_cmp = 0, n_bad = 0;
  rf_wb_arbiter dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] v;
    logic [4:0] a0, a1, a2;
    logic iv;
    logic [4:0] rd;
    logic fl;
    logic [4:0] c1;
    logic [2:0] rdy;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [31:0] bsy;
  } vec_t;
  vec_t tbl [18];
  int m_ptr;
  logic [31:0] m_busy;
  logic m_we;
  logic [4:0] m_wa;
  logic [31:0] m_wd;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic idle();
    req_valid = '0; req_addr = '0; iss_valid = 0; iss_rd = 0; flush = 0; chk_ra1 = 0; chk_ra2 = 7;
  endtask
  initial begin
    tbl[0]  = '{3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0};
    tbl[1]  = '{3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b010, 1, 1, DA, 0};
    tbl[2]  = '{3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b100, 1, 2, DB, 0};
    tbl[3]  = '{3'b000, 0, 0, 0, 1, 5, 0, 5, 3'b000, 1, 3, DC, 0};
    tbl[4]  = '{3'b000, 0, 0, 0, 0, 0, 0, 5, 3'b000, 0, 0, 0, 32'h20};
    tbl[5]  = '{3'b010, 0, 5, 0, 0, 0, 0, 5, 3'b010, 0, 0, 0, 32'h20};
    tbl[6]  = '{3'b000, 0, 0, 0, 0, 0, 0, 5, 3'b000, 1, 5, DB, 32'h20};
    tbl[7]  = '{3'b000, 0, 0, 0, 0, 0, 0, 5, 3'b000, 0, 0, 0, 0};
    tbl[8]  = '{3'b001, 7, 0, 0, 0, 0, 0, 7, 3'b001, 0, 0, 0, 0};
    tbl[9]  = '{3'b000, 0, 0, 0, 1, 7, 0, 7, 3'b000, 1, 7, DA, 0};
    tbl[10] = '{3'b000, 0, 0, 0, 0, 0, 0, 7, 3'b000, 0, 0, 0, 32'h80};
    tbl[11] = '{3'b100, 0, 0, 0, 1, 0, 0, 0, 3'b100, 0, 0, 0, 32'h80};
    tbl[12] = '{3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h80};
    tbl[13] = '{3'b000, 0, 0, 0, 1, 3, 0, 3, 3'b000, 0, 0, 0, 32'h80};
    tbl[14] = '{3'b001, 3, 0, 0, 1, 9, 0, 3, 3'b001, 0, 0, 0, 32'h88};
    tbl[15] = '{3'b000, 0, 0, 0, 1, 4, 1, 3, 3'b000, 1, 3, DA, 32'h288};
    tbl[16] = '{3'b000, 0, 0, 0, 0, 0, 0, 3, 3'b000, 0, 0, 0, 32'h10};
    tbl[17] = '{3'b000, 0, 0, 0, 0, 0, 0, 4, 3'b000, 0, 0, 0, 32'h10};
    rst = 1; idle(); req_data = {DC, DB, DA};
    @(posedge clk); @(posedge clk);
    @(negedge clk); req_valid = 3'b111; req_addr = {5'd3, 5'd2, 5'd1};
    #1 chk("rst_ready", req_ready, 0);
    @(negedge clk); rst = 0; idle();
    #1 chk("rst_we", rf_we, 0); chk("rst_wa", rf_wa, 0); chk("rst_wd", rf_wd, 0); chk("rst_busy", busy, 0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req_valid = tbl[i].v; req_addr = {tbl[i].a2, tbl[i].a1, tbl[i].a0};
      iss_valid = tbl[i].iv; iss_rd = tbl[i].rd; flush = tbl[i].fl; chk_ra1 = tbl[i].c1; chk_ra2 = 7;
      #1;
      chk($sformatf("t%0d_ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("t%0d_we", i), rf_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("t%0d_wa", i), rf_wa, tbl[i].wa);
        chk($sformatf("t%0d_wd", i), rf_wd, tbl[i].wd);
      end
      chk($sformatf("t%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("t%0d_h1", i), hazard1, tbl[i].bsy[tbl[i].c1]);
      chk($sformatf("t%0d_h2", i), hazard2, tbl[i].bsy[7]);
    end
    @(negedge clk); idle(); req_valid = 3'b110; req_addr = {5'd8, 5'd6, 5'd0}; iss_valid = 1; iss_rd = 6;
    #1 chk("s6_grant", req_ready, 3'b010);
    @(negedge clk); idle(); rst = 1; req_valid = 3'b111; req_addr = {5'd3, 5'd2, 5'd1};
    #1 chk("s6_we_inflight", rf_we, 1); chk("s6_ready_rst", req_ready, 0);
    @(negedge clk); rst = 0;
    #1 chk("s6_we", rf_we, 0); chk("s6_wa", rf_wa, 0); chk("s6_wd", rf_wd, 0);
    chk("s6_busy", busy, 0); chk("s6_next_grant", req_ready, 3'b001);
    @(negedge clk); rst = 1; idle();
    @(negedge clk); rst = 0;
    m_ptr = 0; m_busy = 0; m_we = 0; m_wa = 0; m_wd = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [4:0] ga;
      logic [31:0] nb;
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      req_valid = N'($urandom);
      for (int s = 0; s < N; s++) begin
        req_addr[5*s +: 5] = 5'($urandom_range(0, 7));
        req_data[32*s +: 32] = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) != 0); iss_rd = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 19) == 0);
      chk_ra1 = 5'($urandom_range(0, 7)); chk_ra2 = 5'($urandom_range(0, 7));
      g = rst ? -1 : pick(req_valid, m_ptr);
      #1;
      chk("rnd_ready", req_ready, g < 0 ? 0 : 32'(1) << g);
      chk("rnd_we", rf_we, m_we);
      if (m_we) begin
        chk("rnd_wa", rf_wa, m_wa);
        chk("rnd_wd", rf_wd, m_wd);
      end
      chk("rnd_busy", busy, m_busy);
      chk("rnd_h1", hazard1, m_busy[chk_ra1]);
      chk("rnd_h2", hazard2, m_busy[chk_ra2]);
      @(posedge clk);
      if (rst) begin
        m_ptr = 0; m_busy = 0; m_we = 0; m_wa = 0; m_wd = 0;
      end else begin
        nb = flush ? 0 : m_busy;
        if (m_we) nb[m_wa] = 0;
        if (iss_valid && iss_rd != 0) nb[iss_rd] = 1;
        m_busy = nb;
        m_we = 0;
        if (g >= 0) begin
          ga = req_addr[5*g +: 5];
          m_we = ga != 0; m_wa = ga; m_wd = req_data[32*g +: 32];
          m_ptr = (g + 1) % N;
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of writeback requesters (2..8).
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the number of architectural registers tracked.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  writeback request per source.
REQ-006 req_ready  output  NREQ  grant; request consumed when valid&ready.
REQ-007 req_addr  input  NREQ*5  destination register per source; source i in bits [5i+4:5i].
REQ-008 req_data  input  NREQ*32  writeback data per source; source i in bits [32i+31:32i].
REQ-009 iss_valid  input  1  an instruction is issued that will write iss_rd.
REQ-010 iss_rd  input  5  destination register of the issued instruction.
REQ-011 flush  input  1  clear all pending-write state.
REQ-012 chk_ra1, chk_ra2  input  5 each  source registers to hazard-check.
REQ-013 hazard1, hazard2  output  1 each  chk_raN has a pending write.
REQ-014 rf_we, rf_wa, rf_wd  output  1/5/32  register-file write port drive.
REQ-015 busy  output  DEPTH  pending-write scoreboard vector.

Function
REQ-016 Arbitration SHALL be round-robin: the search starts at ptr and goes ptr, ptr+1, ..., wrapping modulo NREQ; the first valid source is granted.
REQ-017 At most one req_ready bit SHALL be high per cycle, only for a source whose req_valid is high; req_ready is combinational from req_valid and ptr.
REQ-018 After a grant to source g, ptr SHALL become (g+1) mod NREQ; with no grant, ptr is unchanged.
REQ-019 A granted request SHALL appear on rf_we/rf_wa/rf_wd exactly one cycle later (registered stage).
REQ-020 rf_we SHALL pulse for one cycle per accepted request and be 0 when no request was accepted in the prior cycle.
REQ-021 A request with addr 0 SHALL be accepted, but it SHALL produce rf_we=0.
REQ-022 busy[r] SHALL be set on the edge where iss_valid=1 and iss_rd=r, for r≠0.
REQ-023 busy[r] SHALL clear on the edge where rf_we=1 and rf_wa=r.
REQ-024 When a set and a clear target the same r in the same edge, the set SHALL win.
REQ-025 flush=1 SHALL clear every busy bit on that edge; an iss_valid on the same edge SHALL still set its bit (order: flush, then clear, then set).
REQ-026 flush SHALL NOT cancel an in-flight rf_we; a committed write still occurs.
REQ-027 busy[0] SHALL be constant 0.
REQ-028 hazardN SHALL equal busy[chk_raN], combinationally.
REQ-029 Re-issue to an already-busy register (WAW) SHALL leave the bit set; there is no counting.

Reset
REQ-030 While rst=1 at an edge, the block SHALL set rf_we=0, rf_wa=0, rf_wd=0, busy=0 and ptr=0.
REQ-031 While rst=1, req_ready SHALL be forced to all zeros, and no request is consumed.
REQ-032 A request accepted in the cycle before a reset edge SHALL be dropped; rf_we stays 0 after reset.

Structure
REQ-033 The constants RF_ADDR_W=5 and XLEN=32 and the typedef wb_req_t {addr, data} SHALL reside in the shared package rf_ctrl_pkg.
REQ-034 The round-robin grant logic SHALL be a sub-module rr_arbiter (parameter N; ports req, ptr, gnt, gnt_idx), instantiated once.

Verification
REQ-035 Scenario 1 (rotation): NREQ=3, all valid for 3 cycles with addr 1/2/3 and data A/B/C -> grants 0,1,2 in order; rf_wa sequence 1,2,3, each one cycle after its grant.
REQ-036 Scenario 2 (scoreboard): iss rd=5, then chk_ra1=5 -> hazard1=1; source 1 writes r5 -> hazard1=0 on the edge after the rf_we=1 cycle.
REQ-037 Scenario 3 (simultaneous set/clear): rf_we to r7 on the same edge as iss rd=7 -> busy[7]=1 afterwards.
REQ-038 Scenario 4 (x0): iss rd=0 and a request with addr 0 -> busy[0]=0, req_ready=1, and rf_we stays 0.
REQ-039 Scenario 5 (flush): busy={r3,r9}, then flush together with iss rd=4 and an in-flight rf_we to r3 -> busy={r4} only and the r3 write is still issued.
REQ-040 Scenario 6 (reset mid-operation): assert rst in the cycle after a grant -> rf_we=0, busy=0, and the next grant goes to source 0.
